// File: rtl/noc_local_inject_arbiter.sv
// Packet-atomic round-robin arbiter that shares the tile's NoC local injection port.
// A grant is held from the first flit to the last flit, so wormhole packets never interleave.
module noc_local_inject_arbiter #(
  parameter int BW            = 32,
  parameter int BWB           = BW/8,
  parameter int N_REQ         = 2,
  parameter int MAX_PKT_FLITS = 256,
  parameter int CNT_W         = $clog2(MAX_PKT_FLITS+1),
  parameter int GID_W         = $clog2(N_REQ)
) (
  input  logic                 clk_line,
  input  logic                 clk_line_rst_high,
  input  logic [N_REQ-1:0]     req_TVALID,
  input  logic [N_REQ*BW-1:0]  req_TDATA,
  input  logic [N_REQ*BWB-1:0] req_TKEEP,
  input  logic [N_REQ-1:0]     req_TLAST,
  output logic [N_REQ-1:0]     req_TREADY,
  output logic                 out_TVALID,
  output logic [BW-1:0]        out_TDATA,
  output logic [BWB-1:0]       out_TKEEP,
  output logic                 out_TLAST,
  input  logic                 out_TREADY,
  output logic [GID_W-1:0]     grant_id,
  output logic                 busy,
  output logic                 pkt_done,
  output logic                 err_overlength,
  input  logic                 err_clear
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PASS = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [GID_W-1:0] last_grant;
  logic [GID_W-1:0] grant_pick;
  logic [CNT_W-1:0] flit_cnt;
  logic             force_last;
  logic             xfer;
  logic             pkt_end;

  // First valid requester strictly after the previous winner, wrapping modulo N_REQ.
  function automatic logic [GID_W-1:0] rr_pick(input logic [N_REQ-1:0] vld,
                                               input logic [GID_W-1:0] last);
    logic [GID_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && vld[idx]) begin
        pick  = GID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign grant_pick = rr_pick(req_TVALID, last_grant);
  assign busy       = (state == S_PASS);

  always_comb begin
    state_nxt  = state;
    out_TVALID = 1'b0;
    out_TDATA  = '0;
    out_TKEEP  = '0;
    out_TLAST  = 1'b0;
    req_TREADY = '0;
    xfer       = 1'b0;
    pkt_end    = 1'b0;
    force_last = (flit_cnt == CNT_W'(MAX_PKT_FLITS-1));
    case (state)
      S_IDLE: begin
        if (|req_TVALID) state_nxt = S_PASS;
      end
      S_PASS: begin
        // Pure pass-through of the granted slice; overlength cut is OR-ed into TLAST.
        out_TVALID           = req_TVALID[grant_id];
        out_TDATA            = req_TDATA[grant_id*BW +: BW];
        out_TKEEP            = req_TKEEP[grant_id*BWB +: BWB];
        out_TLAST            = req_TLAST[grant_id] | force_last;
        req_TREADY[grant_id] = out_TREADY;
        xfer                 = out_TVALID & out_TREADY;
        pkt_end              = xfer & out_TLAST;
        if (pkt_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) state <= S_IDLE;
    else                   state <= state_nxt;
  end

  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      grant_id       <= '0;
      last_grant     <= GID_W'(N_REQ-1);
      flit_cnt       <= '0;
      pkt_done       <= 1'b0;
      err_overlength <= 1'b0;
    end else begin
      pkt_done <= pkt_end;
      if (state == S_IDLE && |req_TVALID) grant_id <= grant_pick;
      if (pkt_end) begin
        last_grant <= grant_id;
        flit_cnt   <= '0;
      end else if (xfer) begin
        flit_cnt <= flit_cnt + CNT_W'(1);
      end
      // A forced cut wins over a simultaneous clear; a genuine TLAST on that flit is legal.
      if (pkt_end && force_last && !req_TLAST[grant_id]) err_overlength <= 1'b1;
      else if (err_clear)                                err_overlength <= 1'b0;
    end
  end

endmodule
